dru_bit_gearbox: RTL and testbench

- Sits directly downstream of the NI-DRU wrapper in the HDMI PHY receive path.
- Each cycle it takes 0..S_MAX recovered bits (SAM plus count SAMV) and packs them into fixed W-bit words for the TMDS decoder.
- It emits a one-cycle valid strobe per completed word.
- It also flags invalid counts and supports word-boundary slipping.

---
 rtl/dru_bit_gearbox.sv | 109 ++++++++++
 tb/tb_dru_bit_gearbox.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dru_bit_gearbox.sv
// Packs 0..S_MAX recovered DRU bits per cycle into W-bit TMDS words; a word completed by cycle k's input is strobed in cycle k+1.
// No backpressure: input is accepted every EN cycle; optional word-boundary slip under DRU_BIT_GEARBOX_BITSLIP_EN.
module dru_bit_gearbox #(
   parameter int W     = 10,
   parameter int S_MAX = 10,
   parameter int CNT_W = 4
) (
   input  logic               CLK,
   input  logic               RST,
`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
   input  logic               BITSLIP,
`endif
   input  logic               EN,
   input  logic [CNT_W-1:0]   SAMV,
   input  logic [S_MAX-1:0]   SAM,
   output logic [W-1:0]       DOUT,
   output logic               DOUT_VLD,
   output logic [CNT_W:0]     FILL,
   output logic               ERR
);

   localparam int FW = CNT_W + 1;
   localparam int T_W = CNT_W + 2;
   localparam logic [CNT_W-1:0] S_MAX_C = CNT_W'(S_MAX);
   localparam logic [T_W-1:0]   W_C     = T_W'(W);
   localparam logic [S_MAX-1:0] ONES    = '1;

   logic [2*W-1:0] acc_q, acc_d;
   logic [FW-1:0]  fill_q, fill_d;
   logic [W-1:0]   dout_q, dout_d;
   logic           dout_vld_q, dout_vld_d;
   logic           err_q, err_d;

   logic           samv_ok;
   logic [CNT_W-1:0] n;
   logic [S_MAX-1:0] sam_m;
   logic [2*W-1:0] c;
   logic [T_W-1:0] t;

`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
   logic           slip_pend_q, slip_pend_d;
`endif

   always_comb begin
      samv_ok    = (SAMV <= S_MAX_C);
      n          = (EN && samv_ok) ? SAMV : '0;
      sam_m      = SAM & ~(ONES << n);
      c          = acc_q | ({{(2*W-S_MAX){1'b0}}, sam_m} << fill_q);
      t          = T_W'(fill_q) + T_W'(n);
      err_d      = err_q | (EN && !samv_ok);
      acc_d      = acc_q;
      fill_d     = fill_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;

`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
      // A pending slip eats the oldest bit of this cycle's stream before extraction;
      // further pulses while pending are absorbed.
      slip_pend_d = slip_pend_q ? 1'b1 : BITSLIP;
      if (slip_pend_q && (t != '0)) begin
         c           = c >> 1;
         t           = t - T_W'(1);
         slip_pend_d = 1'b0;
      end
`endif

      if (t >= W_C) begin
         dout_d     = c[W-1:0];
         dout_vld_d = 1'b1;
         acc_d      = c >> W;
         fill_d     = FW'(t - W_C);
      end else begin
         acc_d      = c;
         fill_d     = FW'(t);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_q      <= '0;
         fill_q     <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         fill_q     <= fill_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         err_q      <= err_d;
      end
   end

`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         slip_pend_q <= 1'b0;
      end else begin
         slip_pend_q <= slip_pend_d;
      end
   end
`endif

   assign DOUT     = dout_q;
   assign DOUT_VLD = dout_vld_q;
   assign FILL     = fill_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_dru_bit_gearbox.sv
// Scoreboard bench for dru_bit_gearbox: a bit-queue model pushes expected words as stimulus is driven.
module tb_dru_bit_gearbox;

   localparam int W = 10;
   localparam int S_MAX = 10;
   localparam int CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             BITSLIP = 1'b0;
   logic             EN = 1'b0;
   logic [CNT_W-1:0] SAMV = '0;
   logic [S_MAX-1:0] SAM = '0;
   logic [W-1:0]     DOUT;
   logic             DOUT_VLD;
   logic [CNT_W:0]   FILL;
   logic             ERR;

   dru_bit_gearbox #(.W(W), .S_MAX(S_MAX), .CNT_W(CNT_W)) dut (
      .CLK      (CLK),
      .RST      (RST),
`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
      .BITSLIP  (BITSLIP),
`endif
      .EN       (EN),
      .SAMV     (SAMV),
      .SAM      (SAM),
      .DOUT     (DOUT),
      .DOUT_VLD (DOUT_VLD),
      .FILL     (FILL),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   logic         mdl_bits[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mdl_dout = '0;
   logic         mdl_err = 1'b0;
   logic         mdl_slip = 1'b0;
   logic         exp_vld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_outputs();
      chk("dout_vld", 32'(DOUT_VLD), 32'(exp_vld));
      if (exp_vld) mdl_dout = exp_q.pop_front();
      chk("dout", 32'(DOUT), 32'(mdl_dout));
      chk("fill", 32'(FILL), mdl_bits.size());
      chk("err", 32'(ERR), 32'(mdl_err));
   endtask

   task automatic do_reset();
      RST = 1'b1; EN = 1'b1; SAMV = 4'd10; SAM = 10'h3FF; BITSLIP = 1'b0;
      mdl_bits.delete(); exp_q.delete();
      mdl_dout = '0; mdl_err = 1'b0; mdl_slip = 1'b0; exp_vld = 1'b0;
      @(posedge CLK); #1;
      check_outputs();
      RST = 1'b0; EN = 1'b0;
   endtask

   task automatic drive(input logic en, input int samv, input logic [S_MAX-1:0] sam, input logic slip);
      logic [W-1:0] w;
      logic old_slip, used;
      EN = en; SAMV = CNT_W'(samv); SAM = sam; BITSLIP = slip;
      if (en && samv <= S_MAX)
         for (int i = 0; i < samv; i++) mdl_bits.push_back(sam[i]);
      if (en && samv > S_MAX) mdl_err = 1'b1;
      old_slip = mdl_slip; used = 1'b0;
      if (old_slip && mdl_bits.size() > 0) begin
         void'(mdl_bits.pop_front());
         used = 1'b1;
      end
      mdl_slip = old_slip ? !used : slip;
      exp_vld = 1'b0;
      if (mdl_bits.size() >= W) begin
         for (int i = 0; i < W; i++) w[i] = mdl_bits.pop_front();
         exp_q.push_back(w);
         exp_vld = 1'b1;
      end
      @(posedge CLK); #1;
      BITSLIP = 1'b0;
      check_outputs();
   endtask

   initial begin
      #2;
      do_reset();

      // steady full-rate words
      for (int i = 0; i < 6; i++) drive(1'b1, 10, 10'h155, 1'b0);

      // mixed counts with an invalid SAMV in between
      do_reset();
      drive(1'b1, 9, 10'h1FF, 1'b0);
      drive(1'b1, 11, 10'h1FF, 1'b0);
      drive(1'b1, 1, 10'h001, 1'b0);

      // carry across words, then prove the leftover bits are zero
      do_reset();
      drive(1'b1, 7, 10'h07F, 1'b0);
      drive(1'b1, 7, 10'h000, 1'b0);
      drive(1'b1, 6, 10'h03F, 1'b0);

      // EN gating, including an out-of-range SAMV that must not raise ERR
      do_reset();
      drive(1'b1, 3, 10'h3FD, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 10, 10'h3FF, 1'b0);
      drive(1'b0, 15, 10'h3FF, 1'b0);

      // reset mid-word
      drive(1'b1, 3, 10'h3FF, 1'b0);
      do_reset();
      drive(1'b1, 10, 10'h2AA, 1'b0);

      // random counts and garbage above SAMV
      for (int i = 0; i < 300; i++)
         drive(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 11)),
               S_MAX'($urandom), 1'b0);

`ifdef DRU_BIT_GEARBOX_BITSLIP_EN
      do_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 10, (i % 2) ? 10'h01F : 10'h3E0, 1'b0);
      for (int p = 0; p < 10; p++) begin
         drive(1'b1, 10, (p % 2) ? 10'h01F : 10'h3E0, 1'b1);
         for (int i = 0; i < 3; i++) drive(1'b1, 10, (i % 2) ? 10'h3E0 : 10'h01F, 1'b0);
      end
      // pulse while empty and idle waits for the first later bit
      do_reset();
      drive(1'b0, 0, 10'h000, 1'b1);
      drive(1'b0, 0, 10'h000, 1'b0);
      drive(1'b1, 10, 10'h3E0, 1'b0);
      drive(1'b1, 10, 10'h01F, 1'b0);
      drive(1'b1, 10, 10'h3E0, 1'b0);
      // pulse while already pending is absorbed
      drive(1'b0, 0, 10'h000, 1'b1);
      drive(1'b0, 0, 10'h000, 1'b1);
      drive(1'b1, 10, 10'h01F, 1'b0);
      drive(1'b1, 10, 10'h3E0, 1'b0);
      for (int i = 0; i < 40; i++)
         drive(1'b1, int'($urandom_range(0, 10)), S_MAX'($urandom), 1'($urandom_range(0, 5) == 0));
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
